// File: rtl/seq_detect_param.sv
// Programmable N-symbol sequence detector with overlap control, prefix
// progress for the LEDs, and a saturating match counter.
module seq_detect_param #(
  parameter int                 W       = 2,
  parameter int                 N       = 3,
  parameter logic [N*W-1:0]     PATTERN = {2'b00, 2'b10, 2'b11},
  parameter int                 CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_sym,
  input  logic                     overlap,
  input  logic                     clear_cnt,
  output logic                     match,
  output logic [$clog2(N+1)-1:0]   progress,
  output logic [CNT_W-1:0]         match_cnt
);
  localparam int                PW   = $clog2(N+1);
  localparam int                NW   = N * W;
  localparam logic [PW-1:0]     N_P  = PW'(N);
  localparam logic [NW-1:0]     ONES = '1;

  logic [NW-1:0]    hist_q, hist_d, hist_sh;
  logic [PW-1:0]    fill_q, fill_d, fill_n;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  generate
    if (N == 1) begin : g_one
      assign hist_sh = in_sym;
    end else begin : g_many
      assign hist_sh = {hist_q[(N-1)*W-1:0], in_sym};
    end
  endgenerate

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    fill_n  = (fill_q == N_P) ? N_P : fill_q + PW'(1);
    if (in_valid) begin
      hist_d  = hist_sh;
      hit     = (fill_n == N_P) && (hist_sh == PATTERN);
      match_d = hit;
      // A non-overlapping match forgets the history; an overlapping one keeps it full.
      if (hit) fill_d = overlap ? N_P : '0;
      else     fill_d = fill_n;
    end
    if (clear_cnt)                 cnt_d = '0;
    else if (hit && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Longest p (bounded by fill) whose newest p symbols equal the first p pattern symbols.
  always_comb begin
    logic [NW-1:0] mask, pfx;
    progress = '0;
    mask     = '0;
    pfx      = '0;
    for (int p = 1; p <= N; p++) begin
      mask = ONES >> ((N - p) * W);
      pfx  = PATTERN >> ((N - p) * W);
      if (PW'(p) <= fill_q && (hist_q & mask) == pfx) progress = PW'(p);
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Clocked, parametrised successor to the board-level "00->10->11" switch sequence detector.
- Detects a programmable N-symbol sequence of W-bit symbols, sampled only on in_valid strobes.
- Supports overlapping and non-overlapping matching, exposes match progress for LEDs, and keeps a saturating match counter.
- Sits between the switch-sampling/strobe logic and the LED drivers on the EGO1 top level.

Parameters:
- W, 2: symbol width in bits (switch bits per symbol).
- N, 3: sequence length in symbols; N >= 1.
- PATTERN, {2'b00,2'b10,2'b11}: N*W-bit target sequence; the first symbol is in the MSBs.
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  accept in_sym at this edge.
- in_sym  input  W  current symbol (e.g. {x2,x1}).
- overlap  input  1  1 = overlapping matches; 0 = history restarts after a match.
- clear_cnt  input  1  synchronous clear of match_cnt.
- match  output  1  one-cycle registered pulse, high after the edge that accepts the completing symbol.
- progress  output  $clog2(N+1)  matched-prefix length of the current history, 0..N.
- match_cnt  output  CNT_W  number of matches, saturating.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values:
  - match=0, match_cnt=0, progress=0.
  - Internal history hist (N symbols) = 0; fill counter = 0.
- State:
  - hist: shift register of the last N accepted symbols, newest at the LSB end.
  - fill: 0..N, the count of valid history symbols.
- Acceptance edge (in_valid=1, rst=0):
  - hist_n = {hist[N-2:0], in_sym}.
  - fill_n = min(fill+1, N).
  - hit = (fill_n==N) && (hist_n==PATTERN).
  - match <= hit.
  - On hit with overlap=0, fill <= 0.
  - On hit with overlap=1, fill <= N.
  - Otherwise fill <= fill_n and hist <= hist_n. hist is always updated.
- in_valid=0: hist and fill hold; match <= 0. Idle gaps of any length do not break a partial match.
- Latency: match is high for exactly the one cycle following the accepting edge. Back-to-back accepted completions (overlap=1) give match high on consecutive cycles.
- progress: combinational from registered hist/fill. It is the largest p in 0..fill such that the newest p history symbols equal the first p PATTERN symbols.
  - After a non-overlap match, progress=0.
  - After an overlap match, progress=N.
- match_cnt:
  - Increments at an edge where hit=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clear_cnt=1 forces 0 and has priority over a simultaneous hit (result 0).
- overlap is sampled at the same edge as the completing symbol; changing it mid-stream affects only later matches.
- rst has priority over in_valid and clear_cnt. Reset mid-sequence discards all partial progress, and match is 0 in the cycle after reset.
- N=1: every accepted symbol equal to PATTERN matches, and overlap has no effect.
- No X propagation: in_sym is ignored when in_valid=0.

Test Plan:
- Defaults; accept 00,10,11 with one idle cycle between each -> progress 1,2,0; match high one cycle after the 11 edge; match_cnt=1.
- Defaults; accept 00,00,10,11 -> progress 1,1,2, then match at the 4th symbol, match_cnt=1. Accept 00,10,10,11 -> no match, progress ends 0, match_cnt unchanged.
- PATTERN={01,01,01}; accept 01 five times consecutively:
  - overlap=1 -> match high after symbols 3,4,5 (3 consecutive cycles), match_cnt=3.
  - overlap=0 -> match only after symbol 3, match_cnt=1, progress=2 at end.
- Defaults; accept 00,10, assert rst one cycle, then accept 11 -> no match, progress=0, match_cnt=0.
- CNT_W=2; produce 5 matches -> match_cnt 1,2,3,3,3. Then clear_cnt on the same edge as a 6th completion -> match=1, match_cnt=0.
- Defaults; accept 00, hold in_valid=0 for 10 cycles with in_sym toggling randomly, then accept 10,11 -> match after 11, match_cnt=1.
